// File: rtl/sw_countdown_psec.sv
// Loadable MM:SS.cc BCD countdown timer clocked by the 100 Hz centisecond tick.
// Counts down to 00:00.00, then holds and flags expiry until reloaded or reset.
module sw_countdown_psec (
  input  logic       clk_psec,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] preset_min_high,
  input  logic [3:0] preset_min_low,
  input  logic [3:0] preset_sec_high,
  input  logic [3:0] preset_sec_low,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] psec_low,
  output logic [3:0] psec_high,
  output logic [3:0] sec_low,
  output logic [3:0] sec_high,
  output logic [3:0] min_low,
  output logic [3:0] min_high,
  output logic       running,
  output logic       expired,
  output logic       done_pulse,
  output logic       sec_tick
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] psec_low_q, psec_low_d, psec_high_q, psec_high_d;
  logic [3:0] sec_low_q, sec_low_d, sec_high_q, sec_high_d;
  logic [3:0] min_low_q, min_low_d, min_high_q, min_high_d;
  logic       done_pulse_q, done_pulse_d, sec_tick_q, sec_tick_d;
  logic       count_zero, count_one;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  assign count_zero = (psec_low_q == 4'd0) && (psec_high_q == 4'd0) && (sec_low_q == 4'd0) &&
                      (sec_high_q == 4'd0) && (min_low_q == 4'd0) && (min_high_q == 4'd0);
  assign count_one  = (psec_low_q == 4'd1) && (psec_high_q == 4'd0) && (sec_low_q == 4'd0) &&
                      (sec_high_q == 4'd0) && (min_low_q == 4'd0) && (min_high_q == 4'd0);

  always_comb begin
    state_d      = state_q;
    psec_low_d   = psec_low_q;
    psec_high_d  = psec_high_q;
    sec_low_d    = sec_low_q;
    sec_high_d   = sec_high_q;
    min_low_d    = min_low_q;
    min_high_d   = min_high_q;
    done_pulse_d = 1'b0;
    sec_tick_d   = 1'b0;

    if (load) begin
      state_d     = StIdle;
      psec_low_d  = 4'd0;
      psec_high_d = 4'd0;
      sec_low_d   = clamp_digit(preset_sec_low, 4'd9);
      sec_high_d  = clamp_digit(preset_sec_high, 4'd5);
      min_low_d   = clamp_digit(preset_min_low, 4'd9);
      min_high_d  = clamp_digit(preset_min_high, 4'd9);
    end else if (stop) begin
      // stop outranks start in every state; it only has an effect in RUN
      if (state_q == StRun) state_d = StIdle;
    end else if (start && (state_q == StIdle)) begin
      if (count_zero) begin
        state_d      = StDone;
        done_pulse_d = 1'b1;
      end else begin
        state_d = StRun;
      end
    end else if (state_q == StRun) begin
      if (count_one || count_zero) begin
        state_d      = StDone;
        done_pulse_d = 1'b1;
        psec_low_d   = 4'd0;
      end else if (psec_low_q != 4'd0) begin
        psec_low_d = psec_low_q - 4'd1;
      end else begin
        psec_low_d = 4'd9;
        if (psec_high_q != 4'd0) begin
          psec_high_d = psec_high_q - 4'd1;
        end else begin
          psec_high_d = 4'd9;
          sec_tick_d  = 1'b1;
          if (sec_low_q != 4'd0) begin
            sec_low_d = sec_low_q - 4'd1;
          end else begin
            sec_low_d = 4'd9;
            if (sec_high_q != 4'd0) begin
              sec_high_d = sec_high_q - 4'd1;
            end else begin
              sec_high_d = 4'd5;
              // count is nonzero here, so a minute borrow always has a source
              if (min_low_q != 4'd0) begin
                min_low_d = min_low_q - 4'd1;
              end else begin
                min_low_d  = 4'd9;
                min_high_d = min_high_q - 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_psec or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      psec_low_q   <= 4'd0;
      psec_high_q  <= 4'd0;
      sec_low_q    <= 4'd0;
      sec_high_q   <= 4'd0;
      min_low_q    <= 4'd0;
      min_high_q   <= 4'd0;
      done_pulse_q <= 1'b0;
      sec_tick_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      psec_low_q   <= psec_low_d;
      psec_high_q  <= psec_high_d;
      sec_low_q    <= sec_low_d;
      sec_high_q   <= sec_high_d;
      min_low_q    <= min_low_d;
      min_high_q   <= min_high_d;
      done_pulse_q <= done_pulse_d;
      sec_tick_q   <= sec_tick_d;
    end
  end

  assign psec_low   = psec_low_q;
  assign psec_high  = psec_high_q;
  assign sec_low    = sec_low_q;
  assign sec_high   = sec_high_q;
  assign min_low    = min_low_q;
  assign min_high   = min_high_q;
  assign running    = (state_q == StRun);
  assign expired    = (state_q == StDone);
  assign done_pulse = done_pulse_q;
  assign sec_tick   = sec_tick_q;

endmodule

// File: tb/tb_sw_countdown_psec.sv
// Directed self-checking bench for sw_countdown_psec; count is viewed as a
// 24-bit hex word so BCD digits read directly as MMSScc.
module tb_sw_countdown_psec;

  logic       clk_psec = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] preset_min_high = 4'd0, preset_min_low = 4'd0;
  logic [3:0] preset_sec_high = 4'd0, preset_sec_low = 4'd0;
  logic [3:0] psec_low, psec_high, sec_low, sec_high, min_low, min_high;
  logic       running, expired, done_pulse, sec_tick;
  logic [23:0] count;
  int tests = 0;
  int fails = 0;

  sw_countdown_psec dut (
    .clk_psec        (clk_psec),
    .reset           (reset),
    .load            (load),
    .preset_min_high (preset_min_high),
    .preset_min_low  (preset_min_low),
    .preset_sec_high (preset_sec_high),
    .preset_sec_low  (preset_sec_low),
    .start           (start),
    .stop            (stop),
    .psec_low        (psec_low),
    .psec_high       (psec_high),
    .sec_low         (sec_low),
    .sec_high        (sec_high),
    .min_low         (min_low),
    .min_high        (min_high),
    .running         (running),
    .expired         (expired),
    .done_pulse      (done_pulse),
    .sec_tick        (sec_tick)
  );

  assign count = {min_high, min_low, sec_high, sec_low, psec_high, psec_low};

  always #5 clk_psec = ~clk_psec;

  task automatic tick();
    @(posedge clk_psec);
    #1;
  endtask

  task automatic do_load(input logic [3:0] mh, input logic [3:0] ml,
                         input logic [3:0] sh, input logic [3:0] sl);
    preset_min_high = mh;
    preset_min_low  = ml;
    preset_sec_high = sh;
    preset_sec_low  = sl;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({count, running, expired, done_pulse, sec_tick} !== 28'h0) begin
      fails++;
      $display("FAIL reset_state got=%h req=%h", {count, running, expired, done_pulse, sec_tick},
               28'h0);
    end
    #4 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    do_start();
    tests++;
    if (running !== 1'b1 || count !== 24'h000200) begin
      fails++;
      $display("FAIL basic_start running=%b count=%h req running=1 count=000200", running, count);
    end
    tick();
    tests++;
    if (count !== 24'h000199 || sec_tick !== 1'b1) begin
      fails++;
      $display("FAIL basic_n1 count=%h tick=%b req 000199 tick=1", count, sec_tick);
    end
    tick();
    tests++;
    if (sec_tick !== 1'b0 || count !== 24'h000198) begin
      fails++;
      $display("FAIL basic_n2 count=%h tick=%b req 000198 tick=0", count, sec_tick);
    end
    repeat (99) tick();
    tests++;
    if (count !== 24'h000099 || sec_tick !== 1'b1) begin
      fails++;
      $display("FAIL basic_n101 count=%h tick=%b req 000099 tick=1", count, sec_tick);
    end
    repeat (98) tick();
    tests++;
    if (count !== 24'h000001 || done_pulse !== 1'b0 || running !== 1'b1) begin
      fails++;
      $display("FAIL basic_n199 count=%h done=%b run=%b req 000001 0 1", count, done_pulse,
               running);
    end
    tick();
    tests++;
    if (count !== 24'h000000 || done_pulse !== 1'b1 || expired !== 1'b1 || running !== 1'b0 ||
        sec_tick !== 1'b0) begin
      fails++;
      $display("FAIL basic_n200 count=%h done=%b exp=%b run=%b tick=%b req 000000 1 1 0 0",
               count, done_pulse, expired, running, sec_tick);
    end
    tick();
    tests++;
    if (done_pulse !== 1'b0 || expired !== 1'b1 || count !== 24'h000000) begin
      fails++;
      $display("FAIL basic_hold done=%b exp=%b count=%h req 0 1 000000", done_pulse, expired,
               count);
    end
  endtask

  task automatic test_minute_borrow();
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    do_start();
    tick();
    tests++;
    if (count !== 24'h005999 || sec_tick !== 1'b1) begin
      fails++;
      $display("FAIL minute_borrow count=%h tick=%b req 005999 tick=1", count, sec_tick);
    end
    repeat (100) tick();
    tests++;
    if (count !== 24'h005899) begin
      fails++;
      $display("FAIL minute_plus100 count=%h req 005899", count);
    end
  endtask

  task automatic test_pause_resume();
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    do_start();
    repeat (37) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if (running !== 1'b0 || count !== 24'h000463) begin
      fails++;
      $display("FAIL pause_stop run=%b count=%h req 0 000463", running, count);
    end
    repeat (50) tick();
    tests++;
    if (running !== 1'b0 || count !== 24'h000463) begin
      fails++;
      $display("FAIL pause_hold run=%b count=%h req 0 000463", running, count);
    end
    do_start();
    tests++;
    if (running !== 1'b1 || count !== 24'h000463) begin
      fails++;
      $display("FAIL resume_start run=%b count=%h req 1 000463", running, count);
    end
    tick();
    tests++;
    if (count !== 24'h000462) begin
      fails++;
      $display("FAIL resume_dec count=%h req 000462", count);
    end
  endtask

  task automatic test_load_in_run();
    do_load(4'd0, 4'd0, 4'd1, 4'd0);
    tests++;
    if (running !== 1'b0 || count !== 24'h001000) begin
      fails++;
      $display("FAIL load_in_run run=%b count=%h req 0 001000", running, count);
    end
  endtask

  task automatic test_clamp();
    do_load(4'hC, 4'hA, 4'h7, 4'hF);
    tests++;
    if (count !== 24'h995900 || running !== 1'b0 || expired !== 1'b0) begin
      fails++;
      $display("FAIL clamp count=%h run=%b exp=%b req 995900 0 0", count, running, expired);
    end
  endtask

  task automatic test_zero_done();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    do_start();
    tests++;
    if (expired !== 1'b1 || done_pulse !== 1'b1 || running !== 1'b0) begin
      fails++;
      $display("FAIL zero_start exp=%b done=%b run=%b req 1 1 0", expired, done_pulse, running);
    end
    tick();
    tests++;
    if (done_pulse !== 1'b0 || expired !== 1'b1) begin
      fails++;
      $display("FAIL zero_pulse_clear done=%b exp=%b req 0 1", done_pulse, expired);
    end
    do_start();
    tests++;
    if (expired !== 1'b1 || done_pulse !== 1'b0 || running !== 1'b0) begin
      fails++;
      $display("FAIL done_lock exp=%b done=%b run=%b req 1 0 0", expired, done_pulse, running);
    end
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    tests++;
    if (expired !== 1'b0 || running !== 1'b0 || count !== 24'h000100) begin
      fails++;
      $display("FAIL done_reload exp=%b run=%b count=%h req 0 0 000100", expired, running, count);
    end
  endtask

  task automatic test_async_reset();
    do_load(4'd0, 4'd0, 4'd0, 4'd3);
    do_start();
    repeat (101) tick();
    reset = 1'b1;
    #2;
    tests++;
    if ({count, running, expired, done_pulse, sec_tick} !== 28'h0) begin
      fails++;
      $display("FAIL async_reset got=%h req=%h", {count, running, expired, done_pulse, sec_tick},
               28'h0);
    end
    #1 reset = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tests++;
    if (running !== 1'b0 || expired !== 1'b0 || done_pulse !== 1'b0) begin
      fails++;
      $display("FAIL start_stop_idle run=%b exp=%b done=%b req 0 0 0", running, expired,
               done_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_minute_borrow();
    do_start();
    repeat (3) tick();
    test_load_in_run();
    test_pause_resume();
    test_clamp();
    test_zero_done();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
